instr_mem_banked: RTL and testbench

Parametrised successor to the team's combinational instruction memory. Holds NUM_TYPES independent banks of instructions, one bank per opcode type. Fetches use a valid/ready request channel, a registered 1-cycle read and a back-pressurable response channel. A post-reset init FSM fills every bank with DEFAULT_INSTR, and a load port writes program images. Sits between the fetch unit and the decode stage.

---
 rtl/instr_mem_pkg.sv | 19 +
 rtl/instr_bank_ram.sv | 31 +++
 rtl/instr_mem_banked.sv | 170 +++++++++++++++++
 tb/tb_instr_mem_banked.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the banked instruction memory.
// Request fields are held 32 bits wide so range checks never depend on a port width.
package instr_mem_pkg;

   typedef enum logic {INIT, RUN} fsm_state_e;

   localparam logic [31:0] DEFAULT_INSTR_C = 32'h0000_0000;
   localparam int REQ_FIELD_W = 32;

   typedef struct packed {
      logic [REQ_FIELD_W-1:0] rtype;
      logic [REQ_FIELD_W-1:0] addr;
   } mem_req_t;

   function automatic logic reqInRange(mem_req_t r, int unsigned numTypes, int unsigned depth);
      return (r.rtype < numTypes) && (r.addr < depth);
   endfunction

endpackage

// File: rtl/instr_bank_ram.sv
// One opcode-type bank: simple dual-port RAM with a synchronous, read-first read port.
// The read register holds its value whenever no read is enabled.
module instr_bank_ram #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     wrEn_i,
   input  logic [$clog2(DEPTH)-1:0] wrAddr_i,
   input  logic [DATA_W-1:0]        wrData_i,
   input  logic                     rdEn_i,
   input  logic [$clog2(DEPTH)-1:0] rdAddr_i,
   output logic [DATA_W-1:0]        rdData_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdData_q;

   // Read-first: a same-edge write lands after the old word has been sampled.
   always_ff @(posedge clk) begin
      if (wrEn_i) begin
         mem[wrAddr_i] <= wrData_i;
      end
      if (rdEn_i) begin
         rdData_q <= mem[rdAddr_i];
      end
   end

   assign rdData_o = rdData_q;

endmodule

// File: rtl/instr_mem_banked.sv
// Banked instruction memory: one RAM per opcode type, valid/ready fetch with a
// registered single-stage response, a load port, and a post-reset fill of every bank.
module instr_mem_banked
   import instr_mem_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int NUM_TYPES = 4,
   parameter int DEPTH     = 256,
   parameter logic [DATA_W-1:0] DEFAULT_INSTR = DATA_W'(DEFAULT_INSTR_C),
   localparam int TYPE_W   = $clog2(NUM_TYPES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [TYPE_W-1:0] req_type,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic              rsp_fault,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [TYPE_W-1:0] ld_type,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              init_done
);

   localparam int AW     = $clog2(DEPTH);
   localparam int TOTAL  = NUM_TYPES * DEPTH;
   localparam int CNT_W  = $clog2(TOTAL) + 1;
   localparam int BANK_W = CNT_W - AW;

   fsm_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic fillActive;

   logic rspValid_q, rspValid_d;
   logic rspFault_q, rspFault_d;
   logic [TYPE_W-1:0] rspBank_q, rspBank_d;

   mem_req_t fetchReq, loadReq;
   logic fetchOk, loadFire, accept;
   logic [BANK_W-1:0] fillBank;
   logic [AW-1:0] fillWord, wrAddr;
   logic [DATA_W-1:0] wrData, rspData;
   logic [NUM_TYPES-1:0] bankWe, bankRe;
   logic [DATA_W-1:0] bankRdata [NUM_TYPES];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The counter walks bank-major through every word, then parks in RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(TOTAL - 1)) begin
               state_d = RUN;
            end
         end
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      fillActive = 1'b0;
      init_done  = 1'b0;
      ld_ready   = 1'b0;
      req_ready  = 1'b0;
      case (state_q)
         INIT: fillActive = 1'b1;
         RUN: begin
            init_done = 1'b1;
            ld_ready  = !rst;
            req_ready = !rst && (!rspValid_q || rsp_ready);
         end
         default: fillActive = 1'b0;
      endcase
   end

   assign fetchReq = '{rtype: REQ_FIELD_W'(req_type), addr: REQ_FIELD_W'(req_addr)};
   assign loadReq  = '{rtype: REQ_FIELD_W'(ld_type),  addr: REQ_FIELD_W'(ld_addr)};
   assign fetchOk  = reqInRange(fetchReq, NUM_TYPES, DEPTH);
   assign loadFire = ld_valid && ld_ready && reqInRange(loadReq, NUM_TYPES, DEPTH);
   assign accept   = req_valid && req_ready;
   assign fillBank = cnt_q[CNT_W-1:AW];
   assign fillWord = cnt_q[AW-1:0];

   // All banks share one write address/data; only the enable is per bank.
   always_comb begin
      wrAddr = fillActive ? fillWord : ld_addr[AW-1:0];
      wrData = fillActive ? DEFAULT_INSTR : ld_data;
      for (int b = 0; b < NUM_TYPES; b++) begin
         if (fillActive) begin
            bankWe[b] = (fillBank == BANK_W'(b));
         end else begin
            bankWe[b] = loadFire && (ld_type == TYPE_W'(b));
         end
         bankRe[b] = accept && fetchOk && (req_type == TYPE_W'(b));
      end
   end

   for (genvar g = 0; g < NUM_TYPES; g++) begin : gBank
      instr_bank_ram #(
         .DEPTH  (DEPTH),
         .DATA_W (DATA_W)
      ) uRam (
         .clk      (clk),
         .wrEn_i   (bankWe[g]),
         .wrAddr_i (wrAddr),
         .wrData_i (wrData),
         .rdEn_i   (bankRe[g]),
         .rdAddr_i (req_addr[AW-1:0]),
         .rdData_o (bankRdata[g])
      );
   end

   always_comb begin
      rspValid_d = rspValid_q;
      rspFault_d = rspFault_q;
      rspBank_d  = rspBank_q;
      if (accept) begin
         rspValid_d = 1'b1;
         rspFault_d = !fetchOk;
         rspBank_d  = req_type;
      end else if (rsp_ready) begin
         rspValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rspValid_q <= 1'b0;
         rspFault_q <= 1'b0;
         rspBank_q  <= '0;
      end else begin
         rspValid_q <= rspValid_d;
         rspFault_q <= rspFault_d;
         rspBank_q  <= rspBank_d;
      end
   end

   // Faulted or idle responses present the default word, never stale RAM data.
   always_comb begin
      rspData = DEFAULT_INSTR;
      for (int b = 0; b < NUM_TYPES; b++) begin
         if (rspBank_q == TYPE_W'(b)) begin
            rspData = bankRdata[b];
         end
      end
   end

   assign rsp_valid = rspValid_q;
   assign rsp_fault = rspValid_q && rspFault_q;
   assign rsp_instr = (rspValid_q && !rspFault_q) ? rspData : DEFAULT_INSTR;

endmodule

// File: tb/tb_instr_mem_banked.sv
// Self-checking bench for instr_mem_banked: directed vector table, hand-written
// corner sequences, and a randomized run against a flat array/queue reference model.
module tb_instr_mem_banked;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int NT = 4;
   localparam int DP = 256;
   localparam int TW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic [TW-1:0] req_type = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_instr;
   logic          rsp_fault;
   logic          ld_valid = 1'b0;
   logic          ld_ready;
   logic [TW-1:0] ld_type = '0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;
   logic          init_done;

   int compareCount = 0;
   int failCount = 0;

   logic [DW-1:0] model [NT][DP];

   typedef struct {
      bit          isLoad;
      int unsigned rtype;
      int unsigned addr;
      logic [31:0] data;
      logic [31:0] expInstr;
      bit          expFault;
      string       name;
   } vec_t;
   vec_t vecs[$];

   typedef struct {
      logic [31:0] instr;
      bit          fault;
   } rsp_t;
   rsp_t pend[$];

   instr_mem_banked dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_type  (req_type),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_instr (rsp_instr),
      .rsp_fault (rsp_fault),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_type   (ld_type),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic clearModel();
      for (int t = 0; t < NT; t++)
         for (int a = 0; a < DP; a++)
            model[t][a] = 32'h0;
   endtask

   task automatic waitInit(input string name);
      int cycles = 0;
      checkOutput({name, " req_ready during init"}, 32'(req_ready), 32'h0);
      while (!init_done && cycles < 2000) begin
         @(posedge clk); #1;
         cycles++;
      end
      checkOutput({name, " init cycles"}, 32'(cycles), 32'(NT * DP));
      clearModel();
   endtask

   task automatic loadOnce(input int unsigned t, input int unsigned a, input logic [31:0] d);
      int n = 0;
      ld_valid = 1'b1; ld_type = TW'(t); ld_addr = AW'(a); ld_data = d;
      #1;
      while (!ld_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      checkOutput("load handshake", 32'(ld_ready), 32'h1);
      @(posedge clk); #1;
      ld_valid = 1'b0;
      if (t < NT && a < DP) model[t][a] = d;
   endtask

   // One fetch with the consumer always ready; returns the response seen one cycle after accept.
   task automatic applyStimulus(input int unsigned t, input int unsigned a,
                                output logic [31:0] instr, output logic fault);
      int n = 0;
      req_valid = 1'b1; req_type = TW'(t); req_addr = AW'(a); rsp_ready = 1'b1;
      #1;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      checkOutput("fetch handshake", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      checkOutput("fetch rsp_valid", 32'(rsp_valid), 32'h1);
      instr = rsp_instr;
      fault = rsp_fault;
   endtask

   initial begin
      logic [31:0] instr;
      logic        fault;
      logic [31:0] expOld;
      logic [31:0] bpVal [16];

      // Reset values and the fill duration
      @(posedge clk); #1;
      checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("reset rsp_instr", rsp_instr, 32'h0);
      checkOutput("reset rsp_fault", 32'(rsp_fault), 32'h0);
      checkOutput("reset req_ready", 32'(req_ready), 32'h0);
      checkOutput("reset ld_ready", 32'(ld_ready), 32'h0);
      checkOutput("reset init_done", 32'(init_done), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      waitInit("first");

      // Directed vectors: expected values are written down by hand
      vecs.push_back('{1'b0, 2, 16'h0005, 32'h0,        32'h0,        1'b0, "fetch t2 a5 after init"});
      vecs.push_back('{1'b1, 1, 16'h0001, 32'hDEADBEEF, 32'h0,        1'b0, "load t1 a1"});
      vecs.push_back('{1'b0, 1, 16'h0001, 32'h0,        32'hDEADBEEF, 1'b0, "fetch t1 a1"});
      vecs.push_back('{1'b0, 0, 16'h0001, 32'h0,        32'h0,        1'b0, "fetch t0 a1"});
      vecs.push_back('{1'b0, 0, 16'h0100, 32'h0,        32'h0,        1'b1, "fetch a=DEPTH"});
      vecs.push_back('{1'b0, 0, 16'h00FF, 32'h0,        32'h0,        1'b0, "fetch a=DEPTH-1"});
      vecs.push_back('{1'b1, 1, 16'h0100, 32'h55555555, 32'h0,        1'b0, "load out of range"});
      vecs.push_back('{1'b0, 1, 16'h0000, 32'h0,        32'h0,        1'b0, "fetch t1 a0 no alias"});
      vecs.push_back('{1'b1, 3, 16'h00FF, 32'hAAAA5555, 32'h0,        1'b0, "load t3 aFF"});
      vecs.push_back('{1'b0, 3, 16'h00FF, 32'h0,        32'hAAAA5555, 1'b0, "fetch t3 aFF"});
      vecs.push_back('{1'b0, 2, 16'hFFFF, 32'h0,        32'h0,        1'b1, "fetch aFFFF"});
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].isLoad) begin
            loadOnce(vecs[i].rtype, vecs[i].addr, vecs[i].data);
         end else begin
            applyStimulus(vecs[i].rtype, vecs[i].addr, instr, fault);
            checkOutput({vecs[i].name, " instr"}, instr, vecs[i].expInstr);
            checkOutput({vecs[i].name, " fault"}, 32'(fault), 32'(vecs[i].expFault));
         end
      end

      // Back-pressure: hold the consumer off for 3 cycles, then stream 4 addresses
      for (int a = 10; a <= 14; a++) begin
         bpVal[a] = 32'hB0000000 + 32'(a);
         loadOnce(0, a, bpVal[a]);
      end
      req_valid = 1'b1; req_type = 2'd0; req_addr = 16'd10; rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0; req_addr = 16'd11;
      for (int c = 0; c < 3; c++) begin
         #1;
         checkOutput("stall req_ready", 32'(req_ready), 32'h0);
         checkOutput("stall rsp_valid", 32'(rsp_valid), 32'h1);
         checkOutput("stall rsp_instr", rsp_instr, bpVal[10]);
         @(posedge clk); #1;
      end
      checkOutput("stall held after 3", rsp_instr, bpVal[10]);
      rsp_ready = 1'b1;
      #1;
      checkOutput("release req_ready", 32'(req_ready), 32'h1);
      for (int a = 11; a <= 14; a++) begin
         @(posedge clk); #1;
         checkOutput("stream rsp_valid", 32'(rsp_valid), 32'h1);
         checkOutput("stream rsp_instr", rsp_instr, bpVal[a]);
         if (a < 14) req_addr = AW'(a + 1);
         else req_valid = 1'b0;
      end
      @(posedge clk); #1;
      checkOutput("stream no duplicate", 32'(rsp_valid), 32'h0);

      // Same-cycle load and fetch of one word: old data first, new data next cycle
      expOld = model[3][7];
      ld_valid = 1'b1; ld_type = 2'd3; ld_addr = 16'd7; ld_data = 32'h12345678;
      req_valid = 1'b1; req_type = 2'd3; req_addr = 16'd7; rsp_ready = 1'b1;
      @(posedge clk); #1;
      ld_valid = 1'b0;
      model[3][7] = 32'h12345678;
      checkOutput("collision old data", rsp_instr, expOld);
      @(posedge clk); #1;
      req_valid = 1'b0;
      checkOutput("collision new data", rsp_instr, 32'h12345678);
      @(posedge clk); #1;

      // Randomized traffic against the array/queue model
      pend.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         int unsigned rt, ra, lt, la;
         bit rv, rr, lv, expReady;
         logic [31:0] ld;
         rv = ($urandom_range(0, 9) < 7);
         rr = ($urandom_range(0, 9) < 6);
         lv = ($urandom_range(0, 9) < 3);
         rt = $urandom_range(0, NT - 1);
         ra = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 260) : $urandom_range(0, 15);
         lt = $urandom_range(0, NT - 1);
         la = ($urandom_range(0, 19) == 0) ? 256 : $urandom_range(0, 15);
         ld = $urandom;
         req_valid = rv; req_type = TW'(rt); req_addr = AW'(ra); rsp_ready = rr;
         ld_valid = lv; ld_type = TW'(lt); ld_addr = AW'(la); ld_data = ld;
         #1;
         expReady = (pend.size() == 0) || rr;
         checkOutput("rand req_ready", 32'(req_ready), 32'(expReady));
         checkOutput("rand rsp_valid", 32'(rsp_valid), 32'(pend.size() != 0));
         if (pend.size() != 0) begin
            checkOutput("rand rsp_instr", rsp_instr, pend[0].instr);
            checkOutput("rand rsp_fault", 32'(rsp_fault), 32'(pend[0].fault));
         end
         if (rr && pend.size() != 0) void'(pend.pop_front());
         if (rv && expReady) begin
            if (ra < DP) pend.push_back('{model[rt][ra], 1'b0});
            else pend.push_back('{32'h0, 1'b1});
         end
         if (lv && la < DP) model[lt][la] = ld;
         @(posedge clk); #1;
      end
      req_valid = 1'b0; ld_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      pend.delete();

      // Reset while a response is held: it must vanish and the banks must refill
      loadOnce(2, 9, 32'hCAFEF00D);
      applyStimulus(2, 9, instr, fault);
      checkOutput("pre-reset load visible", instr, 32'hCAFEF00D);
      req_valid = 1'b1; req_type = 2'd2; req_addr = 16'd9; rsp_ready = 1'b0;
      @(posedge clk); #1;
      checkOutput("pre-reset rsp_valid", 32'(rsp_valid), 32'h1);
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("mid reset rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("mid reset init_done", 32'(init_done), 32'h0);
      rst = 1'b0;
      rsp_ready = 1'b1;
      waitInit("re-init");
      applyStimulus(2, 9, instr, fault);
      checkOutput("after re-init word cleared", instr, 32'h0);
      checkOutput("after re-init fault", 32'(fault), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
